dmem_responder: RTL

//  Responder (memory side) of the mem_in_type/mem_out_type data-memory protocol; the

---
 rtl/dmem_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for the mem_in/mem_out data-memory handshake: single outstanding
// request, SRAM-backed, fixed wait states. Optional macro DMEM_RESPONDER_RANDOM_WAIT_EN adds LFSR jitter.
module dmem_responder #(
    parameter int          MEM_DEPTH   = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_fence_i,
    input  logic        mem_instr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o
);

    localparam int WORDS = 1 << MEM_DEPTH;
`ifdef DMEM_RESPONDER_RANDOM_WAIT_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_load_d;
    logic [31:0]          hold_q;
    logic [31:0]          rdata_q;
    logic                 ready_q;
    logic [31:0]          mem_q [WORDS];

    logic                 hit_d;
    logic                 accept_d;
    logic                 is_write_d;
    logic                 is_read_d;
    logic [MEM_DEPTH-1:0] idx_d;
    logic [31:0]          rd_word_d;
    logic                 unused_d;

`ifdef DMEM_RESPONDER_RANDOM_WAIT_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb_d;

    // Fibonacci taps 16,14,13,11; free-running so the jitter is uncorrelated with requests.
    assign lfsr_fb_d = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb_d};
        end
    end

    assign cnt_load_d = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr_q[1:0]);
    assign unused_d   = mem_instr_i ^ (^mem_addr_i[1:0]);
`else
    assign cnt_load_d = CNT_W'(WAIT_CYCLES);
    assign unused_d   = mem_instr_i ^ (^mem_addr_i[1:0]) ^ (^LFSR_SEED);
`endif

    always_comb begin
        hit_d      = (mem_addr_i[31:MEM_DEPTH+2] == BASE_ADDR[31:MEM_DEPTH+2]);
        idx_d      = mem_addr_i[MEM_DEPTH+1:2];
        accept_d   = (state_q == S_IDLE) && mem_valid_i;
        is_write_d = !mem_fence_i && (|mem_wstrb_i);
        is_read_d  = !mem_fence_i && (mem_wstrb_i == 4'b0000);
        rd_word_d  = '0;
        if (is_read_d && hit_d) begin
            rd_word_d = mem_q[idx_d];
        end
    end

    // Array is deliberately not reset so committed writes survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept_d && is_write_d && hit_d) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wstrb_i[i]) begin
                    mem_q[idx_d][8*i +: 8] <= mem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                    if (accept_d) begin
                        cnt_q  <= cnt_load_d;
                        hold_q <= rd_word_d;
                        if (cnt_load_d == '0) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            rdata_q <= rd_word_d;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        rdata_q <= hold_q;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;

endmodule
